fft32_mul_rr_sched: RTL

Round-robin scheduler that shares one signed 16x14 multiplier among NUM_REQ butterfly/twiddle requesters in the fft32 datapath.
- Arbitrates valid/ready requests and issues one multiply per cycle into a fixed-depth pipeline.
- Returns each product on a shared response bus tagged with the requester ID.
- Stalls the whole pipeline under response backpressure.

---
 rtl/fft32_mul_pkg.sv | 16 +
 rtl/fft32_mul_pipe.sv | 59 +++++
 rtl/fft32_mul_rr_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/fft32_mul_pkg.sv
// Shared widths, ID sizing helper and product type for the fft32 multiplier scheduler.
package fft32_mul_pkg;

  localparam int A_WIDTH_DEF = 16;
  localparam int B_WIDTH_DEF = 14;
  localparam int P_WIDTH_DEF = 28;

  // Requester index width; a single requester bit is kept even for tiny pools.
  function automatic int id_width_f(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  typedef logic signed [P_WIDTH_DEF-1:0] product_t;

endpackage

// File: rtl/fft32_mul_pipe.sv
// Fixed-depth multiply pipeline carrying a valid/id sideband, all stages on one enable.
module fft32_mul_pipe #(
  parameter int A_WIDTH  = 16,
  parameter int B_WIDTH  = 14,
  parameter int P_WIDTH  = 28,
  parameter int ID_WIDTH = 2,
  parameter int STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [ID_WIDTH-1:0] in_id,
  input  logic [A_WIDTH-1:0]  in_a,
  input  logic [B_WIDTH-1:0]  in_b,
  output logic                out_valid,
  output logic [ID_WIDTH-1:0] out_id,
  output logic [P_WIDTH-1:0]  out_p,
  output logic                busy
);

  logic [STAGES-1:0]   vld;
  logic [ID_WIDTH-1:0] id_q [STAGES];
  logic [P_WIDTH-1:0]  p_q  [STAGES];
  logic [P_WIDTH-1:0]  ext_a;
  logic [P_WIDTH-1:0]  ext_b;
  logic [P_WIDTH-1:0]  prod;

  // Only the low P_WIDTH bits are kept, so multiplying sign-extended operands
  // modulo 2^P_WIDTH gives the same bits as truncating the full product.
  assign ext_a = P_WIDTH'($signed(in_a));
  assign ext_b = P_WIDTH'($signed(in_b));
  assign prod  = ext_a * ext_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int s = 0; s < STAGES; s++) begin
        id_q[s] <= '0;
        p_q[s]  <= '0;
      end
    end else if (en) begin
      vld[0]  <= in_valid;
      id_q[0] <= in_valid ? in_id : '0;
      p_q[0]  <= in_valid ? prod  : '0;
      for (int s = 1; s < STAGES; s++) begin
        vld[s]  <= vld[s-1];
        id_q[s] <= id_q[s-1];
        p_q[s]  <= p_q[s-1];
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_id    = id_q[STAGES-1];
  assign out_p     = p_q[STAGES-1];
  assign busy      = |vld;

endmodule

// File: rtl/fft32_mul_rr_sched.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ fft32 requesters.
module fft32_mul_rr_sched
  import fft32_mul_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int A_WIDTH    = A_WIDTH_DEF,
  parameter int B_WIDTH    = B_WIDTH_DEF,
  parameter int P_WIDTH    = P_WIDTH_DEF,
  parameter int MUL_STAGES = 2,
  parameter int ID_WIDTH   = id_width_f(NUM_REQ)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic                         busy
);

  logic [1:0]          rst_sync;
  logic                rst_ok;
  logic                advance;
  logic                grant_valid;
  logic                issue;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [A_WIDTH-1:0]  sel_a;
  logic [B_WIDTH-1:0]  sel_b;

  // Reset asserts immediately but grants resume only after a clean two-flop release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_ok  = rst_sync[1];
  assign advance = !rsp_valid || rsp_ready;
  assign issue   = advance && rst_ok && grant_valid;

  // First pass finds the lowest valid index (wrap case); the second overrides it
  // with the lowest valid index at or above rr_ptr when one exists.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_valid = 1'b1;
        grant       = ID_WIDTH'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_WIDTH'(i) >= rr_ptr)) grant = ID_WIDTH'(i);
    end
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_WIDTH'(i)) begin
        req_ready[i] = issue;
        sel_a        = req_a[i*A_WIDTH +: A_WIDTH];
        sel_b        = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  fft32_mul_pipe #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .P_WIDTH  (P_WIDTH),
    .ID_WIDTH (ID_WIDTH),
    .STAGES   (MUL_STAGES)
  ) u_pipe (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .en        (advance),
    .in_valid  (issue),
    .in_id     (grant),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_p     (rsp_p),
    .busy      (busy)
  );

endmodule
